// File: rtl/burst_source_if.sv
// Burst source handshake bundle: request/seed into the source, burst outputs out of it.
// The master modport is the source side; the slave modport is the consumer side.
interface burst_source_if #(
  parameter int unsigned DATA_W = 4
) ();
  logic              req;
  logic [DATA_W-1:0] seed;
  logic              start;
  logic [DATA_W-1:0] data;
  logic              beat;
  logic              busy;
  logic              pend;
  logic              ovf;

  modport master (
    input  req, seed,
    output start, data, beat, busy, pend, ovf
  );

  modport slave (
    output req, seed,
    input  start, data, beat, busy, pend, ovf
  );
endinterface

// File: rtl/burst_source.sv
// Burst stimulus generator: a start pulse followed by BURST_LEN non-zero beats, with a
// one-entry pending slot so that back-to-back bursts issue without an idle cycle.
module burst_source #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  burst_source_if.master bus
);

  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StStart, StBeat} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] cur_q;
  logic [DATA_W-1:0] slot_q;
  logic [DATA_W-1:0] data_q;
  logic              start_q, beat_q, busy_q, pend_q, ovf_q;
  logic              last_beat, consume;

  // Zero is never a legal beat value; it maps to 1.
  function automatic logic [DATA_W-1:0] nz(input logic [DATA_W-1:0] v);
    return (v == '0) ? DATA_W'(1) : v;
  endfunction

  assign last_beat = (state_q == StBeat) && (cnt_q == LastCnt);
  assign consume   = last_beat && pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cur_q   <= '0;
      slot_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      beat_q  <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      // A consuming edge frees the slot, so a coincident request reloads it instead of dropping.
      if (state_q != StIdle && bus.req) begin
        if (!pend_q || consume) begin
          slot_q <= nz(bus.seed);
          pend_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (consume) begin
        pend_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.req) begin
            state_q <= StStart;
            cur_q   <= nz(bus.seed);
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          state_q <= StBeat;
          start_q <= 1'b0;
          beat_q  <= 1'b1;
          data_q  <= cur_q;
          cnt_q   <= '0;
        end
        StBeat: begin
          if (last_beat) begin
            beat_q <= 1'b0;
            data_q <= '0;
            if (pend_q) begin
              state_q <= StStart;
              start_q <= 1'b1;
              cur_q   <= slot_q;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q  <= cnt_q + CntW'(1);
            data_q <= nz(data_q + DATA_W'(1));
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.start = start_q;
  assign bus.data  = data_q;
  assign bus.beat  = beat_q;
  assign bus.busy  = busy_q;
  assign bus.pend  = pend_q;
  assign bus.ovf   = ovf_q;

endmodule
